mult_seq_ctrl: RTL and testbench

//  Sequencer for the 64-bit shift-add multiplier datapath: drives start/c_w/c_shift/done and an

---
 rtl/mult_seq_pkg.sv | 18 +
 rtl/mult_iter_cnt.sv | 35 +++
 rtl/mult_seq_ctrl.sv | 131 +++++++++++++
 tb/tb_mult_seq_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mult_seq_pkg.sv
// -----------------------------------------------------------------------------
// mult_seq_pkg
// Shared definitions for the shift-add multiplier sequencer.
//   WIDTH_DEF : default operand width (iterations per multiply)
//   state_t   : sequencer state encoding (IDLE=0, LOAD=1, ITER=2, DONE=3)
// -----------------------------------------------------------------------------
package mult_seq_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_ITER = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// -----------------------------------------------------------------------------
// mult_iter_cnt
// Iteration counter for the multiplier sequencer. It is cleared during LOAD and
// incremented on every ITER cycle. tc flags the last iteration
// (count == WIDTH-1).
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : increment
//   tc         : terminal count, count == WIDTH-1
// -----------------------------------------------------------------------------
module mult_iter_cnt #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count;

  // The count reaches WIDTH on the final ITER edge. CNT_W can hold WIDTH, and
  // the next LOAD clears the count, so it never wraps.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)   count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + 1'b1;
  end

  assign tc = (count == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// mult_seq_ctrl
// Sequencer for the shift-add multiplier datapath. It loads the multiplier,
// then runs WIDTH add-and-shift iterations steered by the product LSB, and
// holds the result until the consumer takes it.
// Ports:
//   CLK, RST_N           : clock, asynchronous active-low reset
//   req_valid/req_ready  : operand handshake (ready only in IDLE)
//   prod_lsb             : product register bit 0 (current multiplier bit)
//   start, c_w, c_shift  : datapath load / upper-half write / shift-right
//   clr_hi               : force adder output to zero (load clears upper half)
//   done                 : freeze product register
//   res_valid/res_ready  : result handshake (valid only in DONE)
//   busy                 : LOAD or ITER
//   perf_cnt             : completed multiplies (only with MULT_SEQ_CTRL_PERF_EN)
// Optional feature macro: MULT_SEQ_CTRL_PERF_EN
//
// state | meaning
// IDLE  | waiting for req_valid; done=1, req_ready=1
// LOAD  | product <= {0, multiplier}; iteration counter cleared
// ITER  | one add-and-shift per cycle, WIDTH cycles in total
// DONE  | result final and frozen; waits for res_ready
// -----------------------------------------------------------------------------
module mult_seq_ctrl
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        prod_lsb,
  output logic        start,
  output logic        c_w,
  output logic        c_shift,
  output logic        clr_hi,
  output logic        done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy
`ifdef MULT_SEQ_CTRL_PERF_EN
  ,
  output logic [31:0] perf_cnt
`endif
);

  state_t state;
  logic   c_w_ld;
  logic   iter_tc;

  mult_iter_cnt #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .CLK   (CLK),
    .RST_N (RST_N),
    .clr   (state == ST_LOAD),
    .en    (state == ST_ITER),
    .tc    (iter_tc)
  );

  // Outputs are registered together with the state, so each value matches the
  // state that is being entered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= ST_IDLE;
      req_ready <= 1'b1;
      done      <= 1'b1;
      start     <= 1'b0;
      c_w_ld    <= 1'b0;
      clr_hi    <= 1'b0;
      c_shift   <= 1'b0;
      res_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state     <= ST_LOAD;
            req_ready <= 1'b0;
            done      <= 1'b0;
            start     <= 1'b1;
            c_w_ld    <= 1'b1;
            clr_hi    <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_LOAD: begin
          state   <= ST_ITER;
          start   <= 1'b0;
          c_w_ld  <= 1'b0;
          clr_hi  <= 1'b0;
          c_shift <= 1'b1;
        end
        ST_ITER: begin
          if (iter_tc) begin
            state     <= ST_DONE;
            c_shift   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            res_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          // A req_valid seen here is not taken. The request is accepted on a
          // later IDLE cycle.
          if (res_ready) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // In ITER, the upper-half write follows the current multiplier bit in the
  // same cycle. This makes add-and-shift a single step.
  assign c_w = c_w_ld | ((state == ST_ITER) & prod_lsb);

`ifdef MULT_SEQ_CTRL_PERF_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                                perf_cnt <= '0;
    else if ((state == ST_DONE) && res_ready)  perf_cnt <= perf_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mult_seq_ctrl
// Bench for mult_seq_ctrl. It pairs the controller with a 64-bit shift-add
// product register and a 32-bit adder. The expected product is a*b computed
// with plain arithmetic. The expected number of add cycles is the popcount of
// the multiplier.
// -----------------------------------------------------------------------------
module tb_mult_seq_ctrl;

  localparam int W = 32;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        req_valid = 1'b0;
  logic        res_ready = 1'b0;
  logic        req_ready, start, c_w, c_shift, clr_hi, done, res_valid, busy;
  logic        prod_lsb;
  logic [31:0] op_a = '0;   // multiplier, loaded into the low half
  logic [31:0] op_b = '0;   // multiplicand, fed to the adder
  logic [63:0] prod;
  logic [32:0] sum33;
  int          n_cmp = 0;
  int          n_err = 0;
`ifdef MULT_SEQ_CTRL_PERF_EN
  logic [31:0] perf_cnt;
  int          exp_perf = 0;
`endif

  always #5 CLK = ~CLK;

  mult_seq_ctrl dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .prod_lsb  (prod_lsb),
    .start     (start),
    .c_w       (c_w),
    .c_shift   (c_shift),
    .clr_hi    (clr_hi),
    .done      (done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef MULT_SEQ_CTRL_PERF_EN
    ,
    .perf_cnt  (perf_cnt)
`endif
  );

  // Datapath: product register plus adder, steered only by controller outputs.
  assign prod_lsb = prod[0];
  assign sum33    = c_w ? ({1'b0, prod[63:32]} + {1'b0, op_b}) : {1'b0, prod[63:32]};

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) prod <= '0;
    else if (!done) begin
      if (start)        prod <= {(clr_hi ? 32'd0 : sum33[31:0]), op_a};
      else if (c_shift) prod <= {sum33, prod[31:1]};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One multiply: accept, iterate, hold the result for `hold` cycles (with a
  // stray req_valid present), then release. If `both` is set, req_valid is
  // also raised on the release edge.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input int hold, input bit both);
    int          n;
    int          cw_n;
    int          it_n;
    logic [63:0] exp_p;
    exp_p = {32'd0, a} * {32'd0, b};
    n = 0;
    while (!req_ready && n < 10) begin
      @(posedge CLK); #1; n++;
    end
    check("ready_wait", 64'(req_ready), 64'(1));
    op_a = a;
    op_b = b;
    req_valid = 1'b1;
    n = 0; cw_n = 0; it_n = 0;
    // n counts rising edges. The first one is the accept edge.
    do begin
      @(posedge CLK); #1; n++;
      if (n == 1) begin
        req_valid = 1'b0;
        check("load_outs", 64'({start, c_w, clr_hi, busy, done, req_ready}), 64'(6'b111100));
      end
      if (c_shift) begin
        it_n++;
        if (c_w) cw_n++;
      end
    end while (!res_valid && n < 100);
    check("latency", 64'(n), 64'(W + 2));
    check("result", prod, exp_p);
    check("iter_cycles", 64'(it_n), 64'(W));
    check("cw_count", 64'(cw_n), 64'($countones(a)));
    check("done_flag", 64'(done), 64'(1));
    if (hold > 0) begin
      req_valid = 1'b1;
      repeat (hold) begin
        @(posedge CLK); #1;
      end
      check("hold_flags", 64'({res_valid, done, req_ready, busy}), 64'(4'b1100));
      check("hold_result", prod, exp_p);
    end
    req_valid = both;
    res_ready = 1'b1;
    @(posedge CLK); #1;
    res_ready = 1'b0;
    req_valid = 1'b0;
    check("back_idle", 64'({req_ready, busy, res_valid, done, start}), 64'(5'b10010));
`ifdef MULT_SEQ_CTRL_PERF_EN
    exp_perf++;
`endif
  endtask

  initial begin
    int n;
    int it_n;

    repeat (2) @(posedge CLK);
    #1;
    check("reset_outs", 64'({done, req_ready, start, c_w, c_shift, clr_hi, res_valid, busy}),
          64'(8'b11000000));
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;

    do_mult(32'd6, 32'd7, 0, 1'b0);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    do_mult(32'd0, 32'h1234_5678, 0, 1'b0);
    do_mult(32'd5, 32'd0, 0, 1'b1);
    do_mult(32'd9, 32'd11, 10, 1'b0);

    // Reset during the 10th ITER cycle.
    op_a = $urandom;
    op_b = $urandom;
    req_valid = 1'b1;
    n = 0; it_n = 0;
    while (it_n < 10 && n < 50) begin
      @(posedge CLK); #1; n++;
      if (n == 1) req_valid = 1'b0;
      if (c_shift) it_n++;
    end
    check("iter10_reached", 64'(it_n), 64'(10));
    RST_N = 1'b0;
    #1;
    check("rst_async", 64'({done, busy, req_ready, res_valid, c_shift, start}), 64'(6'b101000));
    @(posedge CLK); #1;
    check("rst_hold", 64'({done, busy, req_ready, res_valid, c_shift, start}), 64'(6'b101000));
    @(negedge CLK);
    RST_N = 1'b1;
`ifdef MULT_SEQ_CTRL_PERF_EN
    exp_perf = 0;
`endif
    @(posedge CLK); #1;
    do_mult(32'd3, 32'd3, 0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      do_mult($urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

`ifdef MULT_SEQ_CTRL_PERF_EN
    check("perf_cnt", 64'(perf_cnt), 64'(exp_perf));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
